// File: rtl/gamma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gamma_pkg
// Description : Shared defaults, swap FSM encoding and bypass expansion
//               helper for the programmable gamma corrector.
// Revision    : 1.0 - initial release
// ============================================================================
package gamma_pkg;

    localparam int c_DEF_IN_W  = 8;
    localparam int c_DEF_OUT_W = 12;
    localparam int c_DEF_CH    = 3;
    localparam int c_DEF_CH_W  = 2;

    // Bank swap FSM: armed by the host, applied at the next frame start
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_t;

    // Linear expansion by MSB replication: output bit i takes input bit
    // in_w-1-((out_w-1-i) mod in_w), so 0xFF -> 0xFFF and 0x80 -> 0x808.
    function automatic logic [31:0] gamma_expand(input logic [31:0] x,
                                                 input int          in_w,
                                                 input int          out_w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < out_w) begin
                r[i] = x[in_w - 1 - ((out_w - 1 - i) % in_w)];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gamma_tbl_ram.sv
`default_nettype none
// ============================================================================
// Module      : gamma_tbl_ram
// Description : Simple dual-port table RAM, one write port and one
//               registered read port. The bank bit is the address MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_tbl_ram #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];

    // Host write port; contents are intentionally never reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk) begin
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/gamma_lut_prog.sv
`default_nettype none
// ============================================================================
// Module      : gamma_lut_prog
// Description : Programmable per-channel gamma corrector with double-buffered
//               tables. Bank swap and bypass only change at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_lut_prog
    import gamma_pkg::*;
#(
    parameter int IN_W  = c_DEF_IN_W,
    parameter int OUT_W = c_DEF_OUT_W,
    parameter int CH    = c_DEF_CH,
    parameter int CH_W  = c_DEF_CH_W
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_vs,
    input  logic                I_hs,
    input  logic                I_de,
    input  logic [CH*IN_W-1:0]  I_data,
    input  logic                I_bypass,
    input  logic                I_wr_en,
    input  logic [CH_W-1:0]     I_wr_ch,
    input  logic [IN_W-1:0]     I_wr_addr,
    input  logic [OUT_W-1:0]    I_wr_data,
    output logic                O_wr_ready,
    input  logic                I_swap_req,
    output logic                O_swap_done,
    output logic                O_bank,
    output logic                O_vs,
    output logic                O_hs,
    output logic                O_de,
    output logic [CH*OUT_W-1:0] O_data
);

    swap_state_t          r_state;
    logic                 r_vs_d;
    logic                 r_bypass;
    logic                 w_vs_rise;
    logic                 w_wr_acc;

    logic                 r_vs_s1;
    logic                 r_hs_s1;
    logic                 r_de_s1;
    logic                 r_byp_s1;
    logic [CH*IN_W-1:0]   r_data_s1;
    logic [OUT_W-1:0]     w_rd [CH];
    logic [CH*OUT_W-1:0]  w_pix;

    assign w_vs_rise = I_vs & ~r_vs_d;
    assign w_wr_acc  = I_wr_en & O_wr_ready;

    // Swap FSM: host arms a swap, the bank flips at the next frame start
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            r_state     <= ST_IDLE;
            r_vs_d      <= 1'b0;
            r_bypass    <= 1'b1;
            O_bank      <= 1'b0;
            O_wr_ready  <= 1'b1;
            O_swap_done <= 1'b0;
        end else begin
            r_vs_d      <= I_vs;
            O_swap_done <= 1'b0;
            if (w_vs_rise) begin
                r_bypass <= I_bypass;
            end
            case (r_state)
                ST_IDLE: begin
                    if (I_swap_req) begin
                        r_state    <= ST_PENDING;
                        O_wr_ready <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (w_vs_rise) begin
                        O_bank      <= ~O_bank;
                        O_swap_done <= 1'b1;
                        O_wr_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One table per channel; writes only ever target the inactive bank
    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            logic [OUT_W-1:0] w_exp;

            gamma_tbl_ram #(
                .AW (IN_W + 1),
                .DW (OUT_W)
            ) u_ram (
                .clk       (I_clk),
                .i_wr_en   (w_wr_acc && (I_wr_ch == CH_W'(c))),
                .i_wr_addr ({~O_bank, I_wr_addr}),
                .i_wr_data (I_wr_data),
                .i_rd_addr ({O_bank, I_data[c*IN_W +: IN_W]}),
                .o_rd_data (w_rd[c])
            );

            assign w_exp = OUT_W'(gamma_expand(32'(r_data_s1[c*IN_W +: IN_W]),
                                               IN_W, OUT_W));
            assign w_pix[c*OUT_W +: OUT_W] = r_byp_s1 ? w_exp : w_rd[c];
        end
    endgenerate

    // Two-stage video pipeline: RAM read stage, then output register
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            r_vs_s1   <= 1'b0;
            r_hs_s1   <= 1'b0;
            r_de_s1   <= 1'b0;
            r_byp_s1  <= 1'b1;
            r_data_s1 <= '0;
            O_vs      <= 1'b0;
            O_hs      <= 1'b0;
            O_de      <= 1'b0;
            O_data    <= '0;
        end else begin
            r_vs_s1   <= I_vs;
            r_hs_s1   <= I_hs;
            r_de_s1   <= I_de;
            r_byp_s1  <= r_bypass;
            r_data_s1 <= I_data;
            O_vs      <= r_vs_s1;
            O_hs      <= r_hs_s1;
            O_de      <= r_de_s1;
            O_data    <= r_de_s1 ? w_pix : '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/gamma_lut_prog.md
Name: gamma_lut_prog

Overview:
Programmable multi-channel gamma corrector for the ISP video path. It replaces fixed per-gamma case tables with one RAM-based table per channel, double-buffered in two banks. The host loads the inactive bank, then requests a swap. The swap and the bypass setting take effect only at a frame start, so a frame never mixes two curves. It sits between the colour pipeline (IN_W-bit RGB) and the output formatter (OUT_W-bit).

Parameters:
IN_W, 8, input sample width; table depth is 2**IN_W
OUT_W, 12, output sample width; must satisfy OUT_W >= IN_W
CH, 3, number of colour channels, each with its own table
CH_W, 2, host channel-select width; must satisfy 2**CH_W >= CH

Ports:
I_clk  in  1  pixel clock
I_rst_n  in  1  synchronous active-low reset
I_vs  in  1  vertical sync, active high; rising edge marks frame start
I_hs  in  1  horizontal sync
I_de  in  1  pixel valid
I_data  in  CH*IN_W  channel c occupies bits [c*IN_W +: IN_W]
I_bypass  in  1  requested linear mode, applied at frame start
I_wr_en  in  1  host table write strobe
I_wr_ch  in  CH_W  target channel
I_wr_addr  in  IN_W  table index
I_wr_data  in  OUT_W  table value
O_wr_ready  out  1  high when a write will be accepted
I_swap_req  in  1  one-cycle pulse; arm a bank swap
O_swap_done  out  1  one-cycle pulse when the swap is applied
O_bank  out  1  currently active bank
O_vs, O_hs, O_de  out  1 each  syncs delayed to match data
O_data  out  CH*OUT_W  corrected pixel

Behaviour:
- Reset (I_rst_n low at a clock edge): O_bank=0, swap_pending=0, active bypass=1, O_wr_ready=1, O_swap_done=0, O_vs/O_hs/O_de=0, O_data=0, sync-edge history register=0. Table RAM contents are not reset and are undefined; bypass=1 guarantees no undefined data reaches the output.
- Latency is fixed at 2 cycles for all of O_data, O_vs, O_hs and O_de.
  - Stage 1: synchronous RAM read of the active bank, addressed by I_data; syncs registered.
  - Stage 2: output register.
- While the active bypass is 1: O_data channel = {I_data_ch, (OUT_W-IN_W) MSBs of I_data_ch}, i.e. bit-replication. Example: IN_W=8, OUT_W=12, 0xFF -> 0xFFF, 0x80 -> 0x808.
- When O_de=0, O_data=0 (blanking forced to zero).
- Host writes:
  - A write is accepted when I_wr_en && O_wr_ready.
  - It lands in bank ~O_bank, table I_wr_ch, address I_wr_addr.
  - I_wr_ch >= CH: the write is dropped silently.
  - Writes never touch the active bank, so no read/write collision is possible.
- Swap FSM, states IDLE -> PENDING -> IDLE:
  - IDLE: I_swap_req sets PENDING; O_wr_ready goes 0 on the next cycle.
  - PENDING: on a detected I_vs rising edge (registered I_vs low, I_vs high):
    - O_bank toggles;
    - active bypass <= I_bypass;
    - O_swap_done pulses for 1 cycle;
    - return to IDLE; O_wr_ready returns to 1 on the following cycle.
  - The new bank is used from the first pixel after that edge.
  - I_swap_req while already PENDING is ignored (no double toggle).
  - I_swap_req in the same cycle as an I_vs rising edge while in IDLE: enter PENDING; the swap occurs at the next frame's edge.
- Bypass change without a swap: at every I_vs rising edge, active bypass <= I_bypass; the bank is unchanged.
- Reset asserted mid-frame or during PENDING:
  - everything returns to reset values;
  - the pending swap is lost;
  - table contents are retained.
- Pixels arriving while I_vs=1 are processed normally; no stall and no back-pressure on the video path.

Decomposition:
- Shared package gamma_pkg holds:
  - the default IN_W/OUT_W/CH;
  - swap FSM state encoding (ST_IDLE, ST_PENDING);
  - a function for the bypass bit-replication expansion.
- Natural sub-module: gamma_tbl_ram, a simple dual-port RAM of 2*2**IN_W x OUT_W (bank bit as the address MSB), with one write port and one registered read port. It is instantiated CH times.
- The top level contains the swap FSM, the sync pipeline and the bypass/blanking mux.

Test Plan:
- After reset, with no writes, drive I_data=0x80_40_FF, I_de=1 -> 2 cycles later O_data=0x808_404_FFF, O_bank=0.
- Load bank1 on all channels with value = addr*16; I_bypass=0; pulse I_swap_req; raise I_vs -> O_swap_done 1 cycle after the edge, O_bank=1; first pixel 0x10 -> 0x100 on every channel.
- Write during PENDING -> O_wr_ready=0 and the write is not stored; readback after the next swap shows the old value.
- Two I_swap_req pulses before one I_vs edge -> exactly one toggle (O_bank 0->1), one O_swap_done pulse.
- Swap request mid-frame with continuous pixels -> all pixels of the current frame use the bank-0 curve and the next frame uses bank 1, with no mixed frame.
- Assert I_rst_n=0 for 1 cycle while PENDING -> O_bank=0, bypass=1, no O_swap_done at the next I_vs edge; table contents are intact after re-arming the swap.
